// File: rtl/iter_mul_unit.sv
// Iterative unsigned shift-add multiplier: one partial-product step per clock, 65 cycles per op.
// Returns either half of the full 2*WIDTH product along with a register-file write request.
module iter_mul_unit #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNTW  = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       wa_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       wa3,
  output logic             we3
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [2*WIDTH-1:0]   p_q;
  logic [WIDTH-1:0]     a_q;
  logic                 op_q;
  logic [CNTW-1:0]      cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 we3_q;
  logic [WIDTH-1:0]     result_q;
  logic [4:0]           wa3_q;

  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   p_next;

  // Add the multiplicand into the upper half when the current multiplier bit is set, then shift
  // right with the carry landing in the top bit.
  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
    p_next = {sum, p_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      p_q      <= '0;
      a_q      <= '0;
      op_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we3_q    <= 1'b0;
      result_q <= '0;
      wa3_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          we3_q  <= 1'b0;
          if (start) begin
            a_q     <= a;
            op_q    <= op;
            wa3_q   <= wa_in;
            p_q     <= {{WIDTH{1'b0}}, b};
            cnt_q   <= CNTW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          p_q   <= p_next;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNTW'(1)) begin
            result_q <= op_q ? p_next[2*WIDTH-1:WIDTH] : p_next[WIDTH-1:0];
            done_q   <= 1'b1;
            // x31 is the zero register, so its write is dropped while done still pulses.
            we3_q    <= (wa3_q != 5'd31);
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          we3_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we3_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign we3    = we3_q;
  assign result = result_q;
  assign wa3    = wa3_q;

endmodule

// File: tb/tb_iter_mul_unit.sv
// Directed bench for iter_mul_unit with a tiny register-file model fed by wa3/we3/result.
module tb_iter_mul_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [63:0] a;
  logic [63:0] b;
  logic [4:0]  wa_in;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  wa3;
  logic        we3;

  int total = 0;
  int bad = 0;
  int done_pulses = 0;
  int n;
  logic [63:0] rf [32];

  iter_mul_unit #(.WIDTH(64), .CNTW(7)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .wa_in  (wa_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .wa3    (wa3),
    .we3    (we3)
  );

  always #5 clk = ~clk;

  // Register-file model and done-pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (done) done_pulses++;
    if (we3) rf[wa3] = result;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle start and wait (bounded) for done; returns cycles after the accept edge.
  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic opv,
                       input logic [4:0] wav, output int cyc);
    a = av; b = bv; op = opv; wa_in = wav; start = 1'b1;
    cycle();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 200) begin
      cycle();
      cyc++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    reset = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; wa_in = '0;
    cycle();
    cycle();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we3", we3, 0);
    chk("rst_result", result, 0);
    chk("rst_wa3", wa3, 0);
    reset = 1'b1;
    cycle();

    // Basic MUL 3*5 -> x2
    a = 64'd3; b = 64'd5; op = 1'b0; wa_in = 5'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("mul_busy_after_accept", busy, 1);
    chk("mul_done_after_accept", done, 0);
    n = 0;
    while (!done && n < 200) begin
      cycle();
      n++;
    end
    chk("mul_latency", n, 64);
    chk("mul_busy_in_done", busy, 1);
    chk("mul_we3", we3, 1);
    chk("mul_wa3", wa3, 2);
    chk("mul_result", result, 64'd15);
    cycle();
    chk("mul_done_drop", done, 0);
    chk("mul_busy_drop", busy, 0);
    chk("mul_we3_drop", we3, 0);
    chk("mul_result_hold", result, 64'd15);
    chk("mul_rf_x2", rf[2], 64'd15);
    cycle();

    // UMULH and MUL of all-ones
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd4, n);
    chk("umulh_latency", n, 64);
    chk("umulh_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("umulh_wa3", wa3, 4);
    cycle();
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd4, n);
    chk("mulff_result", result, 64'h0000_0000_0000_0001);
    cycle();
    chk("mulff_rf_x4", rf[4], 64'h1);

    // XZR destination: done pulses, no write
    issue(64'd7, 64'd6, 1'b0, 5'd31, n);
    chk("xzr_done", done, 1);
    chk("xzr_result", result, 64'd42);
    chk("xzr_we3", we3, 0);
    cycle();
    chk("xzr_rf_x31", rf[31], 0);

    // Start pulses while busy are ignored
    done_pulses = 0;
    a = 64'd2; b = 64'd2; op = 1'b0; wa_in = 5'd1; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 9; i++) cycle();
    a = 64'd9; b = 64'd9; wa_in = 5'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      cycle();
      n++;
    end
    chk("busy_result", result, 64'd4);
    chk("busy_wa3", wa3, 1);
    a = 64'd9; b = 64'd9; wa_in = 5'd5; start = 1'b1;
    cycle();
    start = 1'b0;
    chk("busy_done_start_ignored", busy, 0);
    for (int i = 0; i < 70; i++) cycle();
    chk("busy_one_pulse", done_pulses, 1);
    chk("busy_result_hold", result, 64'd4);
    chk("busy_wa3_hold", wa3, 1);

    // Reset mid-operation discards the multiply
    done_pulses = 0;
    a = 64'd10; b = 64'd10; op = 1'b0; wa_in = 5'd3; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 29; i++) cycle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    chk("midrst_busy", busy, 0);
    chk("midrst_result", result, 0);
    chk("midrst_wa3", wa3, 0);
    for (int i = 0; i < 40; i++) cycle();
    chk("midrst_no_done", done_pulses, 0);
    chk("midrst_rf_x3", rf[3], 0);
    issue(64'd0, 64'd12345, 1'b0, 5'd6, n);
    chk("zero_latency", n, 64);
    chk("zero_result", result, 0);
    chk("zero_we3", we3, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iter_mul_unit.md
Name: iter_mul_unit

Overview:
- Iterative 64x64 unsigned shift-add multiplier for the single-cycle datapath.
- Consumes register-file read data (rd1/rd2) as operands.
- Produces a write-back value, destination and write-enable that drive the register file's wd3/wa3/we3.
- Used for MUL (low 64 bits) and UMULH (high 64 bits). Control stalls the PC while busy is high.

Parameters:
- WIDTH, 64, operand and result width in bits. The product register is 2*WIDTH.
- CNTW, 7, iteration counter width. Must hold the value WIDTH.

Ports:
- clk  in  1  system clock, rising-edge active.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk.
- start  in  1  request pulse. Accepted only in IDLE.
- op  in  1  0 = MUL (return product[63:0]), 1 = UMULH (return product[127:64]).
- a  in  WIDTH  multiplicand, from rd1.
- b  in  WIDTH  multiplier, from rd2.
- wa_in  in  5  destination register index.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse in DONE.
- result  out  WIDTH  selected product half. Drives regfile wd3.
- wa3  out  5  latched destination. Drives regfile wa3.
- we3  out  1  regfile write enable. Equals done AND (wa3 != 31).

Behaviour:
- Reset (reset==0 at a rising edge): state=IDLE; busy=0; done=0; we3=0; result=0; wa3=0; internal product, multiplicand and counter cleared. Takes priority over all other inputs, including mid-operation; any in-flight multiply is discarded with no write.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch A=a, op, wa3=wa_in; load P={WIDTH'0, b}; cnt=WIDTH; go to RUN.
  - start=0: stay in IDLE. Outputs hold their last values; done=0 and we3=0.
- RUN, one iteration per clock:
  - Form sum = {1'b0, P[127:64]} + (P[0] ? {1'b0, A} : 0), 65 bits.
  - Update P <= {sum, P[63:1]}, i.e. shift right by one with the carry entering bit 127.
  - Decrement cnt. The edge that brings cnt to 0 moves to DONE.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+64; done=1 during the cycle after edge k+64; return to IDLE at edge k+65. Total 65 cycles from acceptance to done.
- DONE:
  - result = op ? P[127:64] : P[63:0], registered at the DONE entry edge.
  - done=1 for exactly one cycle. we3=1 in that same cycle unless wa3==31: x31 is XZR, so the write is suppressed while done still pulses.
  - Next edge: go to IDLE unconditionally.
- start while busy (RUN or DONE) is ignored. It is not queued, and operands/wa3 do not change.
- result and wa3 hold after DONE until the next accepted start or reset.
- Arithmetic:
  - Unsigned throughout; the full 128-bit product is exact.
  - No overflow flag. MUL truncates to the low 64 bits.
  - Zero operands still take the full 65 cycles; there is no early termination.
- Back-to-back: start asserted in the IDLE cycle directly after DONE is accepted normally. The minimum issue interval is 66 cycles.

Test Plan:
- reset=0 for 2 cycles, then release -> busy=0, done=0, we3=0, result=0, wa3=0.
- Basic MUL: a=3, b=5, op=0, wa_in=2, one-cycle start -> busy for 65 cycles, then done=1, we3=1, wa3=2, result=15. Regfile x2 reads 15 afterwards.
- UMULH: a=b=0xFFFF_FFFF_FFFF_FFFF, op=1, wa_in=4 -> result=0xFFFF_FFFF_FFFF_FFFE. Repeat with op=0 -> result=0x0000_0000_0000_0001.
- XZR: wa_in=31, a=7, b=6, op=0 -> done pulses, result=42, we3 stays 0, x31 still reads 0.
- Busy protection: start a=2, b=2, wa_in=1; pulse start with a=9, b=9 at cycle 10 and again in the DONE cycle -> result=4, wa3=1, only one done pulse.
- Reset mid-op: start a=10, b=10; reset=0 at cycle 30 -> IDLE next edge, no done or we3 pulse. A new start with a=0, b=12345 completes after 65 cycles with result=0.
